// File: rtl/heart_rate_meter.sv
// heart_rate_meter: turns peak-finder pulses into an averaged heart rate in BPM.
// Four-interval ring average, restoring divide of 240000, then double-dabble to BCD.
module heart_rate_meter #(
  parameter int CLK_HZ     = 40_000_000,
  parameter int TICK_DIV   = CLK_HZ / 1000,
  parameter int MIN_IVL_MS = 300,
  parameter int MAX_IVL_MS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       peak_in,
  output logic       beat,
  output logic [7:0] bpm,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid
);
  localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [17:0] DIVIDEND = 18'd240000;
  localparam logic [11:0] MIN_IVL  = 12'(MIN_IVL_MS);
  localparam logic [11:0] MAX_IVL  = 12'(MAX_IVL_MS);
  localparam logic [4:0]  DIV_LAST = 5'd17;
  localparam logic [4:0]  BCD_DONE = 5'd8;

  typedef enum logic {B_IDLE, B_RUN} bstate_t;
  typedef enum logic [1:0] {C_IDLE, C_DIV, C_BCD} cstate_t;

  logic          sync1_reg, sync2_reg, sync3_reg, evt_reg;
  logic [PW-1:0] pre_reg;
  logic          tick;
  logic [11:0]   ivl_reg;
  bstate_t       b_state_reg, b_state_next;
  logic          accept, timeout, ivl_clear;
  logic [11:0]   ring_reg [4];
  logic [11:0]   ring_old;
  logic [1:0]    wp_reg;
  logic [2:0]    fill_reg;
  logic [13:0]   sum_reg, sum_next;
  logic          start;
  cstate_t       c_state_reg, c_state_next;
  logic          load, done, pend_reg;
  logic [4:0]    cnt_reg;
  logic [13:0]   div_reg;
  logic [17:0]   dvd_reg;
  logic [13:0]   rem_reg, rem_step;
  logic [14:0]   trial;
  logic          ge;
  logic [7:0]    quot_reg, quot_step;
  logic [19:0]   dd_reg;
  logic [11:0]   bcd_adj;

  // Two sync flops, an edge-history flop, and a registered edge strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      evt_reg   <= 1'b0;
    end else begin
      sync1_reg <= peak_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      evt_reg   <= sync2_reg & ~sync3_reg;
    end
  end

  assign tick = (pre_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          pre_reg <= '0;
    else if (tick)      pre_reg <= '0;
    else                pre_reg <= pre_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           ivl_reg <= '0;
    else if (ivl_clear)                  ivl_reg <= '0;
    else if (tick && ivl_reg < MAX_IVL)  ivl_reg <= ivl_reg + 12'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) b_state_reg <= B_IDLE;
    else       b_state_reg <= b_state_next;
  end

  // An accepted beat on the final tick wins over the timeout.
  always_comb begin
    b_state_next = b_state_reg;
    beat         = 1'b0;
    accept       = 1'b0;
    timeout      = 1'b0;
    ivl_clear    = 1'b0;
    case (b_state_reg)
      B_IDLE: begin
        if (evt_reg) begin
          beat         = 1'b1;
          ivl_clear    = 1'b1;
          b_state_next = B_RUN;
        end
      end
      B_RUN: begin
        if (evt_reg && ivl_reg >= MIN_IVL) begin
          beat      = 1'b1;
          accept    = 1'b1;
          ivl_clear = 1'b1;
        end else if (tick && ivl_reg >= MAX_IVL - 12'd1) begin
          timeout      = 1'b1;
          b_state_next = B_IDLE;
        end
      end
      default: b_state_next = B_IDLE;
    endcase
  end

  // Until the ring is full the slot at wp has never been written and counts as 0.
  assign ring_old = (fill_reg == 3'd4) ? ring_reg[wp_reg] : 12'd0;
  assign sum_next = accept ? sum_reg + 14'(ivl_reg) - 14'(ring_old) : sum_reg;
  assign start    = accept && (fill_reg >= 3'd3);

  always_ff @(posedge clk) begin
    if (accept) ring_reg[wp_reg] <= ivl_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_reg   <= '0;
      fill_reg <= '0;
      sum_reg  <= '0;
    end else if (timeout) begin
      wp_reg   <= '0;
      fill_reg <= '0;
      sum_reg  <= '0;
    end else if (accept) begin
      wp_reg   <= wp_reg + 2'd1;
      sum_reg  <= sum_next;
      if (fill_reg != 3'd4) fill_reg <= fill_reg + 3'd1;
    end
  end

  assign trial     = {rem_reg, dvd_reg[17]};
  assign ge        = (trial >= {1'b0, div_reg});
  assign rem_step  = ge ? 14'(trial - {1'b0, div_reg}) : trial[13:0];
  assign quot_step = {quot_reg[6:0], ge};

  for (genvar gi = 0; gi < 3; gi++) begin : g_add3
    assign bcd_adj[4*gi +: 4] = (dd_reg[8+4*gi +: 4] >= 4'd5) ?
                                dd_reg[8+4*gi +: 4] + 4'd3 : dd_reg[8+4*gi +: 4];
  end

  always_comb begin
    c_state_next = c_state_reg;
    load         = 1'b0;
    done         = 1'b0;
    case (c_state_reg)
      C_IDLE: begin
        if (start) begin
          load         = 1'b1;
          c_state_next = C_DIV;
        end
      end
      C_DIV: begin
        if (cnt_reg == DIV_LAST) c_state_next = C_BCD;
      end
      C_BCD: begin
        if (cnt_reg == BCD_DONE) begin
          done = 1'b1;
          if (start || pend_reg) begin
            load         = 1'b1;
            c_state_next = C_DIV;
          end else begin
            c_state_next = C_IDLE;
          end
        end
      end
      default: c_state_next = C_IDLE;
    endcase
    if (timeout) begin
      c_state_next = C_IDLE;
      load         = 1'b0;
      done         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) c_state_reg <= C_IDLE;
    else       c_state_reg <= c_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg <= 1'b0;
      cnt_reg  <= '0;
      div_reg  <= '0;
      dvd_reg  <= '0;
      rem_reg  <= '0;
      quot_reg <= '0;
      dd_reg   <= '0;
      bpm      <= '0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
      valid    <= 1'b0;
    end else begin
      if (timeout || load) pend_reg <= 1'b0;
      else if (start)      pend_reg <= 1'b1;

      case (c_state_reg)
        C_DIV: begin
          rem_reg  <= rem_step;
          quot_reg <= quot_step;
          dvd_reg  <= {dvd_reg[16:0], 1'b0};
          if (cnt_reg == DIV_LAST) begin
            cnt_reg <= '0;
            dd_reg  <= {12'd0, quot_step};
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        C_BCD: begin
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg != BCD_DONE) dd_reg <= {bcd_adj, dd_reg[7:0]} << 1;
        end
        default: ;
      endcase

      if (load) begin
        div_reg  <= sum_next;
        dvd_reg  <= DIVIDEND;
        rem_reg  <= '0;
        quot_reg <= '0;
        cnt_reg  <= '0;
      end

      if (timeout) begin
        bpm      <= '0;
        hundreds <= '0;
        tens     <= '0;
        ones     <= '0;
        valid    <= 1'b0;
      end else if (done) begin
        bpm      <= quot_reg;
        hundreds <= dd_reg[19:16];
        tens     <= dd_reg[15:12];
        ones     <= dd_reg[11:8];
        valid    <= 1'b1;
      end
    end
  end

endmodule
